// File: rtl/multi_lane_sender.sv
// Multi-lane serial packet sender: slices one packet across LANES lines, frames each
// slice with a start bit and sequence number, and runs stop-and-wait ARQ on top.
module multi_lane_sender #(
   parameter int LANES          = 4,
   parameter int PKT_BITS       = 836,
   parameter int SEQ_BITS       = 1,
   parameter int BIT_PERIOD     = 1,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                               clk,
   input  logic                               rst_l,
   input  logic                               enable,
   input  logic                               pkt_valid,
   output logic                               pkt_ready,
   input  logic [PKT_BITS-1:0]                pkt_data,
   input  logic                               ack_valid,
   input  logic [SEQ_BITS-1:0]                ack_seq,
   input  logic                               fail_clear,
   output logic [LANES-1:0]                   serial_out,
   output logic                               busy,
   output logic                               send_done,
   output logic [SEQ_BITS-1:0]                seq_num,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic                               link_fail
);

   localparam int LANE_BITS  = PKT_BITS / LANES;
   localparam int FRAME_BITS = 1 + SEQ_BITS + LANE_BITS;
   localparam int CW         = $clog2(FRAME_BITS);
   localparam int PW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int TW         = $clog2(TIMEOUT_CYCLES);
   localparam int RW         = $clog2(MAX_RETRIES + 1);

   generate
      if (PKT_BITS % LANES != 0) begin : g_bad_width
         $error("multi_lane_sender: PKT_BITS must be a multiple of LANES");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, FAIL} state_t;

   state_t                 state_reg, state_next;
   logic [FRAME_BITS-1:0]  shift_reg [LANES];
   logic [FRAME_BITS-1:0]  shift_next [LANES];
   logic [LANE_BITS-1:0]   slice [LANES];
   logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
   logic [PW-1:0]          per_cnt_reg, per_cnt_next;
   logic [TW-1:0]          tmo_cnt_reg, tmo_cnt_next;
   logic [SEQ_BITS-1:0]    seq_reg, seq_next, seq_inc;
   logic [RW-1:0]          retry_reg, retry_next;
   logic                   fail_reg, fail_next;
   logic                   done_reg, done_next;
   logic                   live_reg;

   // Lane 0 takes the most significant slice of the packet.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign slice[gi]      = pkt_data[PKT_BITS-1-gi*LANE_BITS -: LANE_BITS];
         assign serial_out[gi] = (state_reg == SEND) & shift_reg[gi][FRAME_BITS-1];
      end
   endgenerate

   assign seq_inc     = seq_reg + 1'b1;
   assign seq_num     = seq_reg;
   assign retry_count = retry_reg;
   assign link_fail   = fail_reg;
   assign send_done   = done_reg;
   assign busy        = (state_reg == SEND) || (state_reg == WAIT_ACK);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_reg   <= IDLE;
         for (int i = 0; i < LANES; i++) shift_reg[i] <= '0;
         bit_cnt_reg <= '0;
         per_cnt_reg <= '0;
         tmo_cnt_reg <= '0;
         seq_reg     <= '0;
         retry_reg   <= '0;
         fail_reg    <= 1'b0;
         done_reg    <= 1'b0;
         live_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         for (int i = 0; i < LANES; i++) shift_reg[i] <= shift_next[i];
         bit_cnt_reg <= bit_cnt_next;
         per_cnt_reg <= per_cnt_next;
         tmo_cnt_reg <= tmo_cnt_next;
         seq_reg     <= seq_next;
         retry_reg   <= retry_next;
         fail_reg    <= fail_next;
         done_reg    <= done_next;
         live_reg    <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      per_cnt_next = per_cnt_reg;
      tmo_cnt_next = tmo_cnt_reg;
      seq_next     = seq_reg;
      retry_next   = retry_reg;
      fail_next    = fail_reg;
      done_next    = 1'b0;
      // live_reg keeps pkt_ready low while reset is held, since enable may already be high.
      pkt_ready    = live_reg && (state_reg == IDLE) && enable && !fail_reg;

      case (state_reg)
         IDLE: begin
            if (pkt_valid && pkt_ready) begin
               for (int i = 0; i < LANES; i++) shift_next[i] = {1'b1, seq_reg, slice[i]};
               bit_cnt_next = '0;
               per_cnt_next = '0;
               state_next   = SEND;
            end else if (fail_clear) begin
               fail_next  = 1'b0;
               retry_next = '0;
            end
         end
         SEND: begin
            if (per_cnt_reg == PW'(BIT_PERIOD - 1)) begin
               per_cnt_next = '0;
               // Rotate rather than shift: after a full frame the register holds the
               // original frame again, ready for a retransmit without the packet.
               for (int i = 0; i < LANES; i++)
                  shift_next[i] = {shift_reg[i][FRAME_BITS-2:0], shift_reg[i][FRAME_BITS-1]};
               if (bit_cnt_reg == CW'(FRAME_BITS - 1)) begin
                  bit_cnt_next = '0;
                  tmo_cnt_next = '0;
                  done_next    = 1'b1;
                  state_next   = WAIT_ACK;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end else begin
               per_cnt_next = per_cnt_reg + 1'b1;
            end
         end
         WAIT_ACK: begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
            if (ack_valid && (ack_seq == seq_inc)) begin
               seq_next   = seq_inc;
               retry_next = '0;
               state_next = IDLE;
            end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
               if (retry_reg < RW'(MAX_RETRIES)) begin
                  retry_next   = retry_reg + 1'b1;
                  bit_cnt_next = '0;
                  per_cnt_next = '0;
                  state_next   = SEND;
               end else begin
                  fail_next  = 1'b1;
                  state_next = FAIL;
               end
            end
         end
         FAIL: begin
            if (fail_clear) begin
               fail_next  = 1'b0;
               retry_next = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (!enable) begin
         state_next = IDLE;
         retry_next = '0;
         done_next  = 1'b0;
      end
   end

endmodule
